// File: rtl/lvds_pkg.sv
// Framing constants shared by the LVDS transmit framer and its receive counterpart,
// so both ends agree on state encoding, start symbol and FIFO geometry.
package lvds_pkg;

   typedef logic [1:0] state_t;

   localparam state_t STATE_PREAMBLE = 2'd0;
   localparam state_t STATE_START    = 2'd1;
   localparam state_t STATE_DATA     = 2'd2;

   localparam logic [1:0] START_SYM = 2'b11;
   localparam logic [1:0] IDLE_SYM  = 2'b00;

   localparam int DEFAULT_ZERO_LEN = 10;
   localparam int FIFO_DEPTH       = 256;
   localparam int ADDR_W           = 8;
   localparam int PTR_W            = 9;

   // One extra clock beyond the bit count covers the receiver's counter-reset edge.
   function automatic int pre_cycles(input int zero_len);
      return (zero_len + 1) / 2 + 1;
   endfunction

endpackage

// File: rtl/lvds_fifo.sv
// 256x8 single-clock FIFO with 9-bit pointers, occupancy count and status flags.
// rd_data is a registered read of mem[rd_ptr]; it lags a pointer change by one clock.
module lvds_fifo
   import lvds_pkg::*;
#(
   parameter int AFULL_LVL  = 224,
   parameter int AEMPTY_LVL = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_en,
   input  logic [7:0]       wr_data,
   input  logic             rd_en,
   output logic [7:0]       rd_data,
   output logic [PTR_W-1:0] data_count,
   output logic             full,
   output logic             almost_full,
   output logic             almost_empty,
   output logic             overflow
);

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [7:0]       rd_data_reg;
   logic             overflow_reg;
   logic             wr_accept;
   logic             rd_accept;

   assign data_count   = wr_ptr_reg - rd_ptr_reg;
   assign full         = (data_count == PTR_W'(FIFO_DEPTH));
   assign almost_full  = (data_count >= PTR_W'(AFULL_LVL));
   assign almost_empty = (data_count <= PTR_W'(AEMPTY_LVL));
   assign overflow     = overflow_reg;
   assign rd_data      = rd_data_reg;

   assign wr_accept = wr_en && !full;
   assign rd_accept = rd_en && (data_count != '0);

   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_ptr_reg[ADDR_W-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      rd_data_reg <= mem[rd_ptr_reg[ADDR_W-1:0]];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (wr_accept) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (rd_accept) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         if (wr_en && full) begin
            overflow_reg <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/lvds_tx_framer.sv
// LVDS transmit framer: buffers fabric bytes and sends zero preamble, start dibit 11,
// then FRAME_LEN bytes MSB-first as dibits to the DDR output stage in the parent.
module lvds_tx_framer
   import lvds_pkg::*;
#(
   parameter int ZERO_LEN   = DEFAULT_ZERO_LEN,
   parameter int FRAME_LEN  = 16,
   parameter int AFULL_LVL  = 224,
   parameter int AEMPTY_LVL = 32
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic       full,
   output logic       almost_full,
   output logic       almost_empty,
   output logic       overflow,
   output logic       busy,
   output logic [1:0] tx_data
);

   localparam int PRE_CYCLES = pre_cycles(ZERO_LEN);
   localparam int PRE_W      = $clog2(PRE_CYCLES + 1);

   state_t           state_reg;
   state_t           state_next;
   logic [PRE_W-1:0] pre_cnt_reg;
   logic [PRE_W-1:0] pre_cnt_next;
   logic [PRE_W-1:0] pre_inc;
   logic [7:0]       byte_cnt_reg;
   logic [7:0]       byte_cnt_next;
   logic [1:0]       dibit_cnt_reg;
   logic [1:0]       dibit_cnt_next;
   logic [7:0]       sr_reg;
   logic [7:0]       sr_next;
   logic [1:0]       tx_data_reg;
   logic [1:0]       tx_data_next;

   logic             rd_en;
   logic [7:0]       rd_data;
   logic [PTR_W-1:0] data_count;
   logic             pre_done;
   logic             frame_ready;
   logic             last_dibit;
   logic             last_byte;

   lvds_fifo #(
      .AFULL_LVL  (AFULL_LVL),
      .AEMPTY_LVL (AEMPTY_LVL)
   ) u_fifo (
      .clk          (clk),
      .reset_n      (reset_n),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .data_count   (data_count),
      .full         (full),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow)
   );

   // The zero being emitted on this edge already counts toward the preamble.
   assign pre_inc     = (pre_cnt_reg == PRE_W'(PRE_CYCLES)) ? pre_cnt_reg
                                                            : pre_cnt_reg + PRE_W'(1);
   assign pre_done    = (pre_inc == PRE_W'(PRE_CYCLES));
   assign frame_ready = (data_count >= PTR_W'(FRAME_LEN));
   assign last_dibit  = (dibit_cnt_reg == 2'd3);
   assign last_byte   = (byte_cnt_reg == 8'(FRAME_LEN - 1));
   assign tx_data     = tx_data_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= STATE_PREAMBLE;
         pre_cnt_reg   <= '0;
         byte_cnt_reg  <= '0;
         dibit_cnt_reg <= '0;
         sr_reg        <= '0;
         tx_data_reg   <= IDLE_SYM;
      end else begin
         state_reg     <= state_next;
         pre_cnt_reg   <= pre_cnt_next;
         byte_cnt_reg  <= byte_cnt_next;
         dibit_cnt_reg <= dibit_cnt_next;
         sr_reg        <= sr_next;
         tx_data_reg   <= tx_data_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         STATE_PREAMBLE: begin
            if (pre_done && frame_ready) begin
               state_next = STATE_START;
            end
         end
         STATE_START: begin
            state_next = STATE_DATA;
         end
         STATE_DATA: begin
            if (last_dibit && last_byte) begin
               state_next = STATE_PREAMBLE;
            end
         end
         default: begin
            state_next = STATE_PREAMBLE;
         end
      endcase
   end

   // Whole frame is already buffered before START, so every rd_en hits a non-empty FIFO.
   always_comb begin
      pre_cnt_next   = pre_cnt_reg;
      byte_cnt_next  = byte_cnt_reg;
      dibit_cnt_next = dibit_cnt_reg;
      sr_next        = sr_reg;
      tx_data_next   = IDLE_SYM;
      rd_en          = 1'b0;
      busy           = 1'b0;
      case (state_reg)
         STATE_PREAMBLE: begin
            pre_cnt_next = pre_inc;
         end
         STATE_START: begin
            busy           = 1'b1;
            tx_data_next   = START_SYM;
            sr_next        = rd_data;
            rd_en          = 1'b1;
            byte_cnt_next  = '0;
            dibit_cnt_next = '0;
         end
         STATE_DATA: begin
            busy           = 1'b1;
            tx_data_next   = sr_reg[7:6];
            sr_next        = {sr_reg[5:0], 2'b00};
            dibit_cnt_next = dibit_cnt_reg + 2'd1;
            if (last_dibit) begin
               if (last_byte) begin
                  pre_cnt_next = '0;
               end else begin
                  sr_next       = rd_data;
                  rd_en         = 1'b1;
                  byte_cnt_next = byte_cnt_reg + 8'd1;
               end
            end
         end
         default: begin
            pre_cnt_next = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_lvds_tx_framer.sv
// Directed bench for lvds_tx_framer: records the line at every falling edge and
// checks preamble length, start symbol, payload dibits, flags and reset behaviour.
module tb_lvds_tx_framer;

   logic       clk;
   logic       reset_n;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       almost_full;
   logic       almost_empty;
   logic       overflow;
   logic       busy;
   logic [1:0] tx_data;

   int tests_run;
   int tests_failed;

   logic       rec_on;
   logic [1:0] tx_q[$];
   logic       busy_q[$];

   lvds_tx_framer #(
      .ZERO_LEN   (10),
      .FRAME_LEN  (16),
      .AFULL_LVL  (224),
      .AEMPTY_LVL (32)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .full         (full),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .busy         (busy),
      .tx_data      (tx_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rec_on) begin
         tx_q.push_back(tx_data);
         busy_q.push_back(busy);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      wr_data = b;
      wr_en   = 1'b1;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
   endtask

   task automatic do_reset();
      wr_en   = 1'b0;
      wr_data = 8'h00;
      reset_n = 1'b0;
      run(3);
      reset_n = 1'b1;
      tx_q.delete();
      busy_q.delete();
   endtask

   function automatic int find_sym(input int from);
      for (int i = from; i < tx_q.size(); i++) begin
         if (tx_q[i] == 2'b11) return i;
      end
      return -1;
   endfunction

   function automatic int count_nonzero(input int from, input int to);
      int n = 0;
      for (int i = from; i < to && i < tx_q.size(); i++) begin
         if (tx_q[i] != 2'b00) n++;
      end
      return n;
   endfunction

   function automatic int count_busy(input int from, input int to);
      int n = 0;
      for (int i = from; i < to && i < busy_q.size(); i++) begin
         if (busy_q[i]) n++;
      end
      return n;
   endfunction

   function automatic logic [7:0] byte_at(input int idx);
      logic [7:0] b = 8'h00;
      if (idx < 0 || idx + 3 >= tx_q.size()) return 8'hxx;
      for (int k = 0; k < 4; k++) b = {b[5:0], tx_q[idx + k]};
      return b;
   endfunction

   initial begin
      int s, s1, s2, m, n, frames, bad, idx;
      tests_run    = 0;
      tests_failed = 0;
      rec_on       = 1'b1;

      // 1: idle line after reset
      do_reset();
      run(50);
      check("t1_idle_nonzero", count_nonzero(0, tx_q.size()), 0);
      check("t1_idle_busy", count_busy(0, busy_q.size()), 0);
      check("t1_almost_empty", almost_empty, 1);
      check("t1_full", full, 0);
      check("t1_almost_full", almost_full, 0);
      check("t1_overflow", overflow, 0);
      $display("[TB] t1 idle samples %0d", tx_q.size());

      // 2: one frame of 0x00..0x0F
      do_reset();
      for (int i = 0; i < 16; i++) push(8'(i));
      run(100);
      s = find_sym(0);
      check("t2_start_found", s >= 0, 1);
      if (s >= 0) begin
         check("t2_preamble_min", s >= 6, 1);
         check("t2_preamble_zero", count_nonzero(0, s), 0);
         for (int i = 0; i < 16; i++) check($sformatf("t2_byte%0d", i), byte_at(s + 1 + 4 * i), 32'(i));
         check("t2_busy_len", count_busy(0, busy_q.size()), 65);
         check("t2_tail_zero", count_nonzero(s + 65, tx_q.size()), 0);
         $display("[TB] t2 frame start at sample %0d", s);
      end

      // 3: 32 x 0xA5 -> two frames, 6-cycle gap
      do_reset();
      for (int i = 0; i < 32; i++) push(8'hA5);
      run(200);
      s1 = find_sym(0);
      check("t3_start1_found", s1 >= 0, 1);
      if (s1 >= 0) begin
         check("t3_first_byte", byte_at(s1 + 1), 32'hA5);
         s2 = find_sym(s1 + 65);
         check("t3_start2_found", s2 >= 0, 1);
         if (s2 >= 0) begin
            check("t3_gap", s2 - (s1 + 65), 6);
            check("t3_gap_zero", count_nonzero(s1 + 65, s2), 0);
            bad = 0;
            for (int i = 0; i < 16; i++) begin
               if (byte_at(s1 + 1 + 4 * i) !== 8'hA5) bad++;
               if (byte_at(s2 + 1 + 4 * i) !== 8'hA5) bad++;
            end
            check("t3_payload_bad", bad, 0);
            check("t3_no_third", find_sym(s2 + 65), 32'hFFFF_FFFF);
         end
         check("t3_busy_len", count_busy(0, busy_q.size()), 130);
      end
      check("t3_count", 32'(dut.data_count), 0);
      $display("[TB] t3 frames at samples %0d and %0d", s1, s2);

      // 4: fill to full, one dropped write, drain
      do_reset();
      n = 0;
      while (!full && n < 600) begin
         push(8'h3C);
         n++;
      end
      check("t4_full", full, 1);
      check("t4_almost_full", almost_full, 1);
      check("t4_almost_empty", almost_empty, 0);
      check("t4_no_overflow_yet", overflow, 0);
      push(8'hC3);
      check("t4_overflow_set", overflow, 1);
      run(1300);
      check("t4_overflow_sticky", overflow, 1);
      frames = 0;
      bad    = 0;
      idx    = 0;
      s      = find_sym(0);
      while (s >= 0 && s + 64 < tx_q.size() && frames < 64) begin
         frames++;
         for (int i = 0; i < 16; i++) if (byte_at(s + 1 + 4 * i) !== 8'h3C) bad++;
         idx = s + 65;
         s   = find_sym(idx);
      end
      check("t4_frames", frames, 32'(n / 16));
      check("t4_payload_bad", bad, 0);
      check("t4_residual", 32'(dut.data_count), 32'(n % 16));
      $display("[TB] t4 accepted %0d bytes, %0d frames sent", n, frames);

      // 5: 15 bytes never start a frame; the 16th starts one right away
      do_reset();
      for (int i = 0; i < 15; i++) push(8'(8'h80 + i));
      run(40);
      check("t5_no_start", find_sym(0), 32'hFFFF_FFFF);
      m = tx_q.size();
      push(8'h8F);
      run(70);
      check("t5_busy_before", busy_q[m + 1], 0);
      check("t5_busy_rise", busy_q[m + 2], 1);
      check("t5_start_pos", find_sym(m) - m, 3);
      check("t5_first_byte", byte_at(m + 4), 32'h80);
      check("t5_last_byte", byte_at(m + 4 + 60), 32'h8F);
      $display("[TB] t5 frame start at sample %0d", m + 3);

      // 6: asynchronous reset mid-frame
      do_reset();
      for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
      s = -1;
      for (int k = 0; k < 100 && s < 0; k++) begin
         run(1);
         s = find_sym(0);
      end
      check("t6_start_found", s >= 0, 1);
      run(20);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_tx_async", tx_data, 0);
      check("t6_busy_async", busy, 0);
      run(2);
      reset_n = 1'b1;
      check("t6_count_empty", 32'(dut.data_count), 0);
      check("t6_almost_empty", almost_empty, 1);
      m = tx_q.size();
      run(60);
      check("t6_line_quiet", count_nonzero(m, tx_q.size()), 0);
      m = tx_q.size();
      for (int i = 0; i < 16; i++) push(8'(8'h30 + i));
      run(90);
      s = find_sym(m);
      check("t6_restart_found", s >= 0, 1);
      if (s >= 0) begin
         check("t6_first_byte", byte_at(s + 1), 32'h30);
         check("t6_last_byte", byte_at(s + 61), 32'h3F);
      end
      $display("[TB] t6 restart frame at sample %0d", s);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
